serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the combinational full adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using a DIGIT-bit ripple slice and a registered carry.
- Start/busy/done handshake, so ALU and multiplier datapaths can share one narrow adder slice.

---
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock with start/busy/done handshake.
// Optional subtract mode (i_sub port) is compiled in when SERIAL_ADDER_SUB_EN is defined.

module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_carry,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             c;
   } op_t;

   state_t           state, nxt;
   op_t              ops, req;
   logic [CW-1:0]    cnt;
   logic             accept, last;
   logic [DIGIT:0]   cch;
   logic [DIGIT-1:0] dsum;
   logic [WIDTH-1:0] psum_nxt;

   // Subtraction folds into addition: invert Y at capture and force carry-in.
`ifdef SERIAL_ADDER_SUB_EN
   always_comb begin
      req.x = i_x;
      req.y = i_sub ? ~i_y : i_y;
      req.c = i_sub ? 1'b1 : i_carry;
   end
`else
   always_comb begin
      req.x = i_x;
      req.y = i_y;
      req.c = i_carry;
   end
`endif

   assign accept = i_start && (state != RUN);
   assign last   = (cnt == CW'(N - 1));

   // DIGIT-bit ripple slice fed from the bottom of the operand shifters.
   assign cch[0] = ops.c;
   for (genvar g = 0; g < DIGIT; g++) begin : g_fa
      serial_adder_fa u_fa (
         .a  (ops.x[g]),
         .b  (ops.y[g]),
         .ci (cch[g]),
         .s  (dsum[g]),
         .co (cch[g+1])
      );
   end

   // Only the upper WIDTH-DIGIT bits of the partial sum need storage;
   // the newest digit comes straight from the slice.
   if (WIDTH > DIGIT) begin : g_psum
      logic [WIDTH-DIGIT-1:0] psum;
      always_ff @(posedge i_clk) begin
         if (i_rst || accept)
            psum <= '0;
         else if (state == RUN)
            psum <= psum_nxt[WIDTH-1:DIGIT];
      end
      assign psum_nxt = {dsum, psum};
   end else begin : g_nopsum
      assign psum_nxt = dsum;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (i_start) nxt = RUN;
         RUN:     if (last) nxt = DONE;
         DONE:    nxt = i_start ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == RUN);
      o_done = (state == DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ops     <= '0;
         cnt     <= '0;
         o_sum   <= '0;
         o_carry <= 1'b0;
      end else if (accept) begin
         ops <= req;
         cnt <= '0;
      end else if (state == RUN) begin
         ops.x <= ops.x >> DIGIT;
         ops.y <= ops.y >> DIGIT;
         ops.c <= cch[DIGIT];
         cnt   <= cnt + CW'(1);
         if (last) begin
            o_sum   <= psum_nxt;
            o_carry <= cch[DIGIT];
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three configurations (8/1, 16/4, 1/1) and a result scoreboard.
// Subtract-mode checks run when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder;
   int nrun = 0;
   int nfail = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s8, c8, sub8, busy8, done8, co8;
   logic [7:0]  x8, y8, sum8;
   logic        s16, c16, busy16, done16, co16;
   logic [15:0] x16, y16, sum16;
   logic        s1, c1, busy1, done1, co1;
   logic [0:0]  x1, y1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
   logic        sub16 = 1'b0;
   logic        sub1 = 1'b0;
`endif

   logic [8:0]  q8[$];
   logic [16:0] q16[$];
   logic [1:0]  q1[$];

   serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .i_clk(clk), .i_rst(rst), .i_start(s8), .i_x(x8), .i_y(y8), .i_carry(c8),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub(sub8),
`endif
      .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(co8));

   serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
      .i_clk(clk), .i_rst(rst), .i_start(s16), .i_x(x16), .i_y(y16), .i_carry(c16),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub(sub16),
`endif
      .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(co16));

   serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_start(s1), .i_x(x1), .i_y(y1), .i_carry(c1),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub(sub1),
`endif
      .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_carry(co1));

   function automatic logic [8:0] m8(input logic [7:0] x, input logic [7:0] y,
                                     input logic c, input logic sub);
      if (sub) return {1'b0, x} + {1'b0, ~y} + 9'd1;
      return {1'b0, x} + {1'b0, y} + {8'd0, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sub);
      x8 = x; y8 = y; c8 = c; sub8 = sub; s8 = 1'b1;
      q8.push_back(m8(x, y, c, sub));
      tick();
      s8 = 1'b0;
      x8 = 8'($urandom()); y8 = 8'($urandom()); c8 = 1'($urandom()); sub8 = 1'($urandom());
   endtask

   task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic c);
      x16 = x; y16 = y; c16 = c; s16 = 1'b1;
      q16.push_back({1'b0, x} + {1'b0, y} + {16'd0, c});
      tick();
      s16 = 1'b0;
      x16 = 16'($urandom()); y16 = 16'($urandom()); c16 = 1'($urandom());
   endtask

   task automatic start1(input logic x, input logic y, input logic c);
      x1 = x; y1 = y; c1 = c; s1 = 1'b1;
      q1.push_back({1'b0, x} + {1'b0, y} + {1'b0, c});
      tick();
      s1 = 1'b0;
      x1 = 1'($urandom()); y1 = 1'($urandom()); c1 = 1'($urandom());
   endtask

   // Advances until the chosen instance raises o_done; reports elapsed cycles or expiry.
   task automatic wait_on(input int which, input int budget, output int cyc, output bit to);
      logic dn;
      cyc = 0;
      to = 1'b0;
      forever begin
         dn = (which == 8) ? done8 : (which == 16) ? done16 : done1;
         if (dn) break;
         if (cyc >= budget) begin
            to = 1'b1;
            break;
         end
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      int pulses = 0;
      rst = 1'b1; s8 = 0; s16 = 0; s1 = 0;
      x8 = 0; y8 = 0; c8 = 0; sub8 = 0; x16 = 0; y16 = 0; c16 = 0; x1 = 0; y1 = 0; c1 = 0;
      tick(); tick();
      rst = 1'b0;
      nrun++;
      if ({busy8, done8, sum8, co8} !== 11'd0) begin
         nfail++;
         $display("FAIL reset8: busy/done/sum/carry=%b/%b/%h/%b want 0/0/00/0", busy8, done8, sum8, co8);
      end
      nrun++;
      if ({busy16, done16, sum16, co16} !== 19'd0 || {busy1, done1, sum1, co1} !== 4'd0) begin
         nfail++;
         $display("FAIL reset16_1: got %b%b%h%b / %b%b%b%b want all zero",
                  busy16, done16, sum16, co16, busy1, done1, sum1, co1);
      end
      for (int k = 0; k < 20; k++) begin
         if (done8 || busy8) pulses++;
         tick();
      end
      nrun++;
      if (pulses != 0) begin
         nfail++;
         $display("FAIL idle_quiet: got %0d busy/done cycles want 0", pulses);
      end
   endtask

   task automatic test_carry_ripple();
      int bad = 0;
      int cyc;
      bit to;
      logic [8:0] exp;
      start8(8'hFF, 8'h01, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
         tick();
      end
      nrun++;
      if (bad != 0) begin
         nfail++;
         $display("FAIL ripple_busy: got %0d bad RUN cycles want 0", bad);
      end
      exp = q8.pop_front();
      nrun++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || {co8, sum8} !== exp) begin
         nfail++;
         $display("FAIL ripple_result: done=%b busy=%b got %h want done=1 busy=0 %h", done8, busy8, {co8, sum8}, exp);
      end
      tick();
      nrun++;
      if (done8 !== 1'b0) begin
         nfail++;
         $display("FAIL done_pulse_width: got done=%b want 0", done8);
      end
      start8(8'h5A, 8'h25, 1'b1, 1'b0);
      wait_on(8, 20, cyc, to);
      exp = q8.pop_front();
      nrun++;
      if (to || cyc != 8 || {co8, sum8} !== exp || exp !== 9'h080) begin
         nfail++;
         $display("FAIL ripple_5a_25: got %h after %0d cycles (timeout %0d) want %h after 8", {co8, sum8}, cyc, to, 9'h080);
      end
      tick();
   endtask

   task automatic test_handshake();
      int cyc;
      int bad = 0;
      bit to;
      logic [8:0] exp;
      start8(8'h10, 8'h20, 1'b0, 1'b0);
      tick(); tick(); tick();
      x8 = 8'hFF; y8 = 8'hFF; s8 = 1'b1;
      tick();
      s8 = 1'b0;
      wait_on(8, 20, cyc, to);
      exp = q8.pop_front();
      nrun++;
      if (to || cyc != 4 || {co8, sum8} !== 9'h030 || exp !== 9'h030) begin
         nfail++;
         $display("FAIL start_ignored: got %h after %0d (timeout %0d) want 030 after 4", {co8, sum8}, cyc, to);
      end
      start8(8'h01, 8'h01, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h30 || co8 !== 1'b0) bad++;
         tick();
      end
      nrun++;
      if (bad != 0) begin
         nfail++;
         $display("FAIL hold_during_run: got %0d bad cycles want 0", bad);
      end
      exp = q8.pop_front();
      nrun++;
      if (done8 !== 1'b1 || {co8, sum8} !== exp || exp !== 9'h002) begin
         nfail++;
         $display("FAIL back_to_back: done=%b got %h want done=1 002", done8, {co8, sum8});
      end
      nrun++;
      if (q8.size() != 0) begin
         nfail++;
         $display("FAIL no_queue: got %0d pending want 0", q8.size());
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int cyc;
      bit to;
      logic [8:0] exp;
      start8(8'h80, 8'h80, 1'b0, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q8.delete();
      nrun++;
      if ({busy8, done8, sum8, co8} !== 11'd0) begin
         nfail++;
         $display("FAIL abort_state: busy/done/sum/carry=%b/%b/%h/%b want 0/0/00/0", busy8, done8, sum8, co8);
      end
      for (int k = 0; k < 12; k++) begin
         if (done8 || busy8) pulses++;
         tick();
      end
      nrun++;
      if (pulses != 0) begin
         nfail++;
         $display("FAIL abort_quiet: got %0d busy/done cycles want 0", pulses);
      end
      start8(8'h33, 8'h44, 1'b1, 1'b0);
      wait_on(8, 20, cyc, to);
      exp = q8.pop_front();
      nrun++;
      if (to || cyc != 8 || {co8, sum8} !== exp) begin
         nfail++;
         $display("FAIL after_abort: got %h after %0d (timeout %0d) want %h after 8", {co8, sum8}, cyc, to, exp);
      end
      tick();
   endtask

   task automatic test_sweep16();
      int cyc;
      bit to;
      logic [16:0] exp;
      start16(16'hFFFF, 16'h0001, 1'b1);
      wait_on(16, 20, cyc, to);
      exp = q16.pop_front();
      nrun++;
      if (to || cyc != 4 || {co16, sum16} !== 17'h10001 || exp !== 17'h10001) begin
         nfail++;
         $display("FAIL w16_edge: got %h after %0d (timeout %0d) want 10001 after 4", {co16, sum16}, cyc, to);
      end
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 1) == 1) tick();
         start16(16'($urandom()), 16'($urandom()), 1'($urandom()));
         wait_on(16, 20, cyc, to);
         exp = q16.pop_front();
         nrun++;
         if (to || cyc != 4 || {co16, sum16} !== exp) begin
            nfail++;
            $display("FAIL w16_rand[%0d]: got %h after %0d (timeout %0d) want %h after 4", i, {co16, sum16}, cyc, to, exp);
         end
      end
      tick();
   endtask

   task automatic test_width1();
      int cyc;
      bit to;
      logic [1:0] exp;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 1) == 1) tick();
         start1(1'($urandom()), 1'($urandom()), 1'($urandom()));
         wait_on(1, 10, cyc, to);
         exp = q1.pop_front();
         nrun++;
         if (to || cyc != 1 || {co1, sum1} !== exp) begin
            nfail++;
            $display("FAIL w1_rand[%0d]: got %b after %0d (timeout %0d) want %b after 1", i, {co1, sum1}, cyc, to, exp);
         end
      end
      tick();
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      int cyc;
      bit to;
      logic [8:0] exp;
      logic [8:0] want [3];
      logic [7:0] xs [3];
      logic [7:0] ys [3];
      logic       sb [3];
      want[0] = 9'h0FE; xs[0] = 8'h05; ys[0] = 8'h07; sb[0] = 1'b1;
      want[1] = 9'h102; xs[1] = 8'h07; ys[1] = 8'h05; sb[1] = 1'b1;
      want[2] = 9'h00D; xs[2] = 8'h05; ys[2] = 8'h07; sb[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start8(xs[i], ys[i], 1'b1, sb[i]);
         wait_on(8, 20, cyc, to);
         exp = q8.pop_front();
         nrun++;
         if (to || cyc != 8 || {co8, sum8} !== want[i] || exp !== want[i]) begin
            nfail++;
            $display("FAIL sub[%0d]: got %h after %0d (timeout %0d) want %h after 8", i, {co8, sum8}, cyc, to, want[i]);
         end
         tick();
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_carry_ripple();
      test_handshake();
      test_reset_mid();
      test_sweep16();
      test_width1();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end
endmodule
